// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared types and default widths for the BIST March engine.
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    localparam int AD_W_DEF  = 4;
    localparam int OPS_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : bist_pkg
`default_nettype wire

// File: rtl/bist_bin2gray.sv
`default_nettype none
// ============================================================================
// Module      : bist_bin2gray
// Description : Combinational binary-to-Gray code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_bin2gray #(
    parameter int AD_W = 4
) (
    input  logic [AD_W-1:0] bin_i,
    output logic [AD_W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule : bist_bin2gray
`default_nettype wire

// File: rtl/march_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : march_addr_sequencer
// Description : Walks an address window up/down, issuing each address for a
//               programmable number of March ops over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module march_addr_sequencer
    import bist_pkg::*;
#(
    parameter int AD_W  = AD_W_DEF,
    parameter int OPS_W = OPS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             gray,
    input  logic [AD_W-1:0]  lo_addr,
    input  logic [AD_W-1:0]  hi_addr,
    input  logic [OPS_W-1:0] ops,
    input  logic             rdy,
    output logic [AD_W-1:0]  addr,
    output logic [OPS_W-1:0] op_idx,
    output logic             addr_vld,
    output logic             first,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t             state_q, state_d;
    logic [AD_W-1:0]    cnt_q, cnt_d;
    logic [AD_W-1:0]    addr_q, addr_d;
    logic [OPS_W-1:0]   op_q, op_d;
    logic [OPS_W-1:0]   opsm1_q, opsm1_d;
    logic [AD_W-1:0]    lo_q, lo_d;
    logic [AD_W-1:0]    hi_q, hi_d;
    logic               dir_q, dir_d;
    logic               gray_q, gray_d;
    logic               err_q, err_d;

    logic [AD_W-1:0]    gray_cnt_d;
    logic [AD_W-1:0]    end_bound;
    logic [AD_W-1:0]    start_bound;

    bist_bin2gray #(
        .AD_W   (AD_W)
    ) u_bin2gray (
        .bin_i  (cnt_d),
        .gray_o (gray_cnt_d)
    );

    assign end_bound   = dir_q ? hi_q : lo_q;
    assign start_bound = dir_q ? lo_q : hi_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opsm1_d = opsm1_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dir_d   = dir_q;
        gray_d  = gray_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d    = lo_addr;
                    hi_d    = hi_addr;
                    dir_d   = dir;
                    gray_d  = gray;
                    // ops==0 behaves as a single op per address
                    opsm1_d = (ops == '0) ? '0 : ops - OPS_W'(1);
                    if (lo_addr > hi_addr) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = dir ? lo_addr : hi_addr;
                        op_d    = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rdy) begin
                    if (op_q < opsm1_q) begin
                        op_d = op_q + OPS_W'(1);
                    end else begin
                        op_d = '0;
                        // Counter parks on the end bound rather than stepping past it
                        if (cnt_q == end_bound) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = dir_q ? cnt_q + AD_W'(1) : cnt_q - AD_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        addr_d = gray_d ? gray_cnt_d : cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            opsm1_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b0;
            gray_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            opsm1_q <= opsm1_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dir_q   <= dir_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
        end
    end

    assign addr     = addr_q;
    assign op_idx   = op_q;
    assign addr_vld = (state_q == ST_RUN);
    assign first    = addr_vld && (cnt_q == start_bound);
    assign last     = addr_vld && (cnt_q == end_bound);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = done && err_q;

endmodule : march_addr_sequencer
`default_nettype wire

// File: tb/tb_march_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_march_addr_sequencer
// Description : Directed self-checking bench for march_addr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_march_addr_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, dir, gray, rdy;
    logic [3:0] lo_addr, hi_addr;
    logic [2:0] ops;
    logic [3:0] addr;
    logic [2:0] op_idx;
    logic       addr_vld, first, last, busy, done, err;

    int total = 0;
    int bad   = 0;

    march_addr_sequencer #(.AD_W(4), .OPS_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .dir      (dir),
        .gray     (gray),
        .lo_addr  (lo_addr),
        .hi_addr  (hi_addr),
        .ops      (ops),
        .rdy      (rdy),
        .addr     (addr),
        .op_idx   (op_idx),
        .addr_vld (addr_vld),
        .first    (first),
        .last     (last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"},   int'(addr_vld), 0);
        chk({tag, "_busy"},  int'(busy),     0);
        chk({tag, "_done"},  int'(done),     0);
        chk({tag, "_err"},   int'(err),      0);
        chk({tag, "_first"}, int'(first),    0);
        chk({tag, "_last"},  int'(last),     0);
    endtask

    task automatic kick(input logic [3:0] lo, input logic [3:0] hi, input logic d,
                        input logic g, input logic [2:0] n);
        lo_addr = lo; hi_addr = hi; dir = d; gray = g; ops = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b1; gray = 1'b0;
        rdy = 1'b1; lo_addr = '0; hi_addr = '0; ops = '0;
        tick(); tick();
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_addr", int'(addr),   0);
        chk("rst_op",   int'(op_idx), 0);

        // 1: full window ascending, binary, one op per address
        kick(4'd0, 4'd15, 1'b1, 1'b0, 3'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t1_vld",   int'(addr_vld), 1);
            chk("t1_addr",  int'(addr),     i);
            chk("t1_first", int'(first),    (i == 0)  ? 1 : 0);
            chk("t1_last",  int'(last),     (i == 15) ? 1 : 0);
            chk("t1_done",  int'(done),     0);
            tick();
        end
        chk("t1_done_pulse", int'(done),     1);
        chk("t1_err",        int'(err),      0);
        chk("t1_vld_off",    int'(addr_vld), 0);
        chk("t1_busy_done",  int'(busy),     1);
        tick();
        chk("t1_busy_end",   int'(busy),     0);
        chk("t1_done_end",   int'(done),     0);

        // 2: window 3..6 descending, two ops per address
        kick(4'd3, 4'd6, 1'b0, 1'b0, 3'd2);
        for (int k = 0; k < 8; k++) begin
            chk("t2_vld",   int'(addr_vld), 1);
            chk("t2_addr",  int'(addr),     6 - k / 2);
            chk("t2_op",    int'(op_idx),   k % 2);
            chk("t2_first", int'(first),    (k < 2)  ? 1 : 0);
            chk("t2_last",  int'(last),     (k >= 6) ? 1 : 0);
            tick();
        end
        chk("t2_done", int'(done), 1);
        tick();
        chk("t2_done_once", int'(done), 0);
        chk("t2_busy",      int'(busy), 0);

        // 3: Gray ordering over the full range
        begin
            logic [15:0] seen;
            seen = '0;
            kick(4'd0, 4'd15, 1'b1, 1'b1, 3'd1);
            for (int i = 0; i < 16; i++) begin
                chk("t3_addr", int'(addr), gray_tab[i]);
                seen[addr] = 1'b1;
                tick();
            end
            chk("t3_all_seen", int'(seen), 16'hFFFF);
            chk("t3_done",     int'(done), 1);
            tick();
        end

        // 4: backpressure keeps address/op stable, no op skipped
        kick(4'd0, 4'd3, 1'b1, 1'b0, 3'd2);
        chk("t4_a0", int'(addr), 0); chk("t4_o0", int'(op_idx), 0);
        tick();
        chk("t4_a1", int'(addr), 0); chk("t4_o1", int'(op_idx), 1);
        rdy = 1'b0;
        tick();
        chk("t4_hold_a", int'(addr), 0); chk("t4_hold_o", int'(op_idx), 1);
        tick();
        chk("t4_hold2_a", int'(addr), 0); chk("t4_hold2_o", int'(op_idx), 1);
        rdy = 1'b1;
        tick();
        chk("t4_a2", int'(addr), 1); chk("t4_o2", int'(op_idx), 0);
        for (int k = 3; k < 8; k++) begin
            tick();
            chk("t4_seq_a", int'(addr),   k / 2);
            chk("t4_seq_o", int'(op_idx), k % 2);
        end
        tick();
        chk("t4_done", int'(done), 1);
        tick();

        // 5: inverted window reports error without issuing addresses
        kick(4'd9, 4'd2, 1'b1, 1'b0, 3'd1);
        chk("t5_vld",  int'(addr_vld), 0);
        chk("t5_done", int'(done),     1);
        chk("t5_err",  int'(err),      1);
        tick();
        chk("t5_busy", int'(busy), 0);
        chk("t5_err0", int'(err),  0);

        // 6: start ignored while busy, abort, then reset mid-run
        kick(4'd0, 4'd15, 1'b1, 1'b0, 3'd1);
        tick(); tick(); tick();
        chk("t6_a3", int'(addr), 3);
        start = 1'b1; lo_addr = 4'd10;
        tick();
        start = 1'b0;
        chk("t6_ign", int'(addr), 4);
        tick();
        chk("t6_a5", int'(addr), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("t6_abort");
        tick();
        chk("t6_no_done", int'(done), 0);
        kick(4'd0, 4'd15, 1'b1, 1'b0, 3'd1);
        tick(); tick();
        chk("t6_run", int'(addr), 2);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        chk_idle("t6_rst");
        chk("t6_rst_addr", int'(addr),   0);
        chk("t6_rst_op",   int'(op_idx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_march_addr_sequencer
`default_nettype wire
